fp_addsub_pipe: RTL and testbench
=================================

# fp_addsub_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on input and output. It accepts one operation per cycle, does round-to-nearest-even and returns exception flags. Default parameters give bfloat16. It is the next-generation datapath adder in the FP arithmetic cluster, dropping in wherever a streaming add/sub of configurable format is needed.

## Interface
- EXP_W, 8, exponent width (≥3)
- MAN_W, 7, stored mantissa width, excluding the hidden bit (≥2)
- W, EXP_W+MAN_W+1, derived word width; do not override
- clock  in  1  single clock, rising edge
- nreset  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts the pair this cycle
- a, b  in  W  operands {sign, exp, man}
- sub  in  1  0: a+b, 1: a−b (b sign inverted at stage 1)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- result  out  W  rounded result
- flags  out  4  {invalid, overflow, underflow, inexact}

## Operation
- Operand classes:
  - exp==0 is zero; subnormals are flushed to signed zero on input.
  - exp all-ones with man==0 is inf.
  - exp all-ones with man≠0 is NaN.
- Special results:
  - Any NaN operand gives canonical qNaN {0, all-ones, 1 then zeros} (bf16 0x7FC0), invalid=0.
  - inf + (−inf) gives canonical qNaN with invalid=1.
  - inf with any finite operand gives that inf.
  - (+0)+(−0) gives +0; (−0)+(−0) gives −0.
  - x + 0 gives x exactly.
- Stage 1 (align):
  - Classify the operands and swap so the operand with the larger magnitude is A.
  - Compute d = expA−expB.
  - Shift B's significand {1,man,G,R,S} right by min(d, MAN_W+3); every bit shifted out ORs into the sticky bit S.
- Stage 2 (add / normalise):
  - Same effective sign: add.
  - Different effective sign: A−B, which never goes negative after the swap.
  - On carry-out, shift right 1 with sticky preserved and increment the exponent.
  - Otherwise use the leading-zero count L to shift left by L and subtract L from the exponent.
  - A zero sum (exact cancellation) gives +0.
- Stage 3 (round):
  - Round to nearest, ties to even, using G, R|S and the LSB.
  - A mantissa overflow from rounding increments the exponent.
  - inexact = G|R|S.
  - Exponent ≥ all-ones gives ±inf, with overflow=1 and inexact=1.
  - Exponent ≤ 0 gives signed zero, with underflow=1 and inexact=1.
- Result sign is A's effective sign, except for the zero rules above.
- Special-case results bypass the arithmetic. They still travel the pipeline so ordering is preserved.

## Timing
- Latency is 3 cycles from accept to out_valid with no stall; throughput is 1 op/cycle.
- Accept happens when in_valid & in_ready.
- Hand-off happens when out_valid & out_ready.
- Global stall: advance = !out_valid | out_ready. in_ready = advance, combinational; no dependency on in_valid.
- While stalled, every stage register and result/flags hold. Each stage carries a valid bit, and bubbles advance.
- result/flags are registered outputs. They must stay stable while out_valid & !out_ready.
- Reset (synchronous, nreset low at a rising edge):
  - Stage valids, out_valid, result and flags go to 0.
  - In-flight ops are discarded, including those under reset mid-stall.
  - in_ready follows advance, so it is 1 from the first cycle after reset.
- Simultaneous hand-off and accept in the same cycle is legal and loses no data.

## Structure
- Package fp_pkg:
  - fp_class_e enum {ZERO, NORM, INF, NAN}.
  - fp_flags_t packed struct {invalid, overflow, underflow, inexact}.
  - Function to build the canonical qNaN from EXP_W/MAN_W.
- Sub-module lzc_n #(N):
  - Parametrised leading-zero counter with output width $clog2(N+1).
  - All-zero input returns N.
  - Used in stage 2.
- Top is fp_addsub_pipe: three stage-register banks and one advance signal.

## Test plan
- 0x3F80 + 0x4000, sub=0 → 0x4040, flags 0; a→result in exactly 3 cycles with out_ready=1.
- 0x3F80 − 0x3F80 → 0x0000, flags 0; 0x8000 + 0x8000 → 0x8000.
- Rounding:
  - 0x3F80 + 0x3B80 (tie) → 0x3F80, inexact=1.
  - 0x3F80 + 0x3BC0 → 0x3F81, inexact=1.
- Specials and overflow:
  - 0x7F80 + 0xFF80 → 0x7FC0, invalid=1.
  - 0x7FC1 + 0x3F80 → 0x7FC0, invalid=0.
  - 0x7F7F + 0x7F7F → 0x7F80, overflow=1, inexact=1.
- Backpressure: stream 10 random ops with in_valid=1 and drop out_ready for 5 cycles mid-stream → in_ready=0 during the stall, no loss or duplication, order matches the reference model, result held stable.
- Reset mid-stream: pull nreset low with 3 ops in flight → next cycle out_valid=0 and result=0; the first op after release emerges alone 3 cycles later.

Source files
------------

// File: rtl/fp_addsub_pipe_pkg.sv
// Shared types and helpers for the pipelined floating-point adder/subtractor.
package fp_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for fp_addsub_pipe.
interface fp_addsub_pipe_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (output in_valid, a, b, sub, out_ready,
                  input  in_ready, out_valid, result, flags);
  modport slave  (input  in_valid, a, b, sub, out_ready,
                  output in_ready, out_valid, result, flags);
endinterface

// File: rtl/fp_addsub_pipe_lzc.sv
// Leading-zero counter; an all-zero input reports N.
module lzc_n #(parameter int N = 8) (
  input  logic [N-1:0]           i_vec,
  output logic [$clog2(N+1)-1:0] o_cnt
);
  localparam int CW = $clog2(N+1);

  // Scan upward so the highest set bit writes last.
  always_comb begin
    o_cnt = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) o_cnt = CW'(N - 1 - i);
    end
  end
endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/sub (align, add/normalise, round) with one
// global advance shared by every stage register bank.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int W     = EXP_W + MAN_W + 1
) (
  input  logic           clock,
  input  logic           nreset,
  fp_addsub_pipe_if.slave bus
);
  localparam int SW    = MAN_W + 4;
  localparam int SHMAX = MAN_W + 3;
  localparam int LZW   = $clog2(SW + 1);
  localparam int EW    = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam int MRW   = MAN_W + 1;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0]     QNAN = W'(fp_qnan(EXP_W, MAN_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return ZERO;
    if (e != EMAX) return NORM;
    return (m == '0) ? INF : NAN;
  endfunction

  logic w_adv;
  assign w_adv         = !bus.out_valid | bus.out_ready;
  assign bus.in_ready  = w_adv;

  // Stage 1: classify, swap, align
  logic             w_sa, w_sb, w_swap, w_s_hi, w_lost, w_spec;
  logic [EXP_W-1:0] w_ea, w_eb, w_e_hi, w_e_lo, w_d;
  logic [MAN_W-1:0] w_ma, w_mb, w_m_hi, w_m_lo;
  logic [W-1:0]     w_b_eff, w_spec_res;
  logic [LZW-1:0]   w_sh;
  logic [SW-1:0]    w_sig_lo, w_sig_sh, w_sig_b;
  fp_class_e        w_ca, w_cb;
  fp_flags_t        w_spec_fl;

  assign w_sa    = bus.a[W-1];
  assign w_ea    = bus.a[W-2:MAN_W];
  assign w_ma    = bus.a[MAN_W-1:0];
  assign w_sb    = bus.b[W-1] ^ bus.sub;
  assign w_eb    = bus.b[W-2:MAN_W];
  assign w_mb    = bus.b[MAN_W-1:0];
  assign w_b_eff = {w_sb, w_eb, w_mb};

  always_comb begin
    w_ca     = classify(w_ea, w_ma);
    w_cb     = classify(w_eb, w_mb);
    w_swap   = {w_eb, w_mb} > {w_ea, w_ma};
    w_s_hi   = w_swap ? w_sb : w_sa;
    w_e_hi   = w_swap ? w_eb : w_ea;
    w_m_hi   = w_swap ? w_mb : w_ma;
    w_e_lo   = w_swap ? w_ea : w_eb;
    w_m_lo   = w_swap ? w_ma : w_mb;
    w_d      = w_e_hi - w_e_lo;
    w_sh     = (32'(w_d) > SHMAX) ? LZW'(SHMAX) : LZW'(w_d);
    w_sig_lo = {1'b1, w_m_lo, 3'b000};
    w_sig_sh = w_sig_lo >> w_sh;
    w_lost   = |(w_sig_lo & ~({SW{1'b1}} << w_sh));
    w_sig_b  = {w_sig_sh[SW-1:1], w_sig_sh[0] | w_lost};

    w_spec     = 1'b1;
    w_spec_res = '0;
    w_spec_fl  = '0;
    if (w_ca == NAN || w_cb == NAN) begin
      w_spec_res = QNAN;
    end else if (w_ca == INF && w_cb == INF) begin
      w_spec_res        = (w_sa != w_sb) ? QNAN : bus.a;
      w_spec_fl.invalid = (w_sa != w_sb);
    end else if (w_ca == INF) begin
      w_spec_res = bus.a;
    end else if (w_cb == INF) begin
      w_spec_res = w_b_eff;
    end else if (w_ca == ZERO && w_cb == ZERO) begin
      w_spec_res = {w_sa & w_sb, {(W-1){1'b0}}};
    end else if (w_ca == ZERO) begin
      w_spec_res = w_b_eff;
    end else if (w_cb == ZERO) begin
      w_spec_res = bus.a;
    end else begin
      w_spec = 1'b0;
    end
  end

  logic             r1_valid, r1_spec, r1_sign, r1_eff_sub;
  logic [W-1:0]     r1_spec_res;
  fp_flags_t        r1_spec_fl;
  logic [EXP_W-1:0] r1_exp;
  logic [SW-1:0]    r1_sig_a, r1_sig_b;

  // Stage 2: add/subtract and normalise
  logic [SW:0]    w_sum;
  logic [LZW-1:0] w_lz;
  logic [SW-1:0]  w_norm;
  logic [EW-1:0]  w_exp2;

  assign w_sum = r1_eff_sub ? ({1'b0, r1_sig_a} - {1'b0, r1_sig_b})
                            : ({1'b0, r1_sig_a} + {1'b0, r1_sig_b});

  lzc_n #(.N(SW)) u_lzc (.i_vec(w_sum[SW-1:0]), .o_cnt(w_lz));

  always_comb begin
    if (w_sum[SW]) begin
      w_norm = {w_sum[SW:2], |w_sum[1:0]};
      w_exp2 = EW'(r1_exp) + EW'(1);
    end else begin
      w_norm = w_sum[SW-1:0] << w_lz;
      w_exp2 = EW'(r1_exp) - EW'(w_lz);
    end
  end

  logic          r2_valid, r2_spec, r2_sign, r2_zero;
  logic [W-1:0]  r2_spec_res;
  fp_flags_t     r2_spec_fl;
  logic [EW-1:0] r2_exp;
  logic [SW-1:0] r2_sig;

  // Stage 3: round to nearest even, range check
  logic           w_g, w_rs, w_rup;
  logic [MRW-1:0] w_man_r;
  logic [EW-1:0]  w_exp3;
  logic [W-1:0]   w_res;
  fp_flags_t      w_fl;

  assign w_g     = r2_sig[2];
  assign w_rs    = |r2_sig[1:0];
  assign w_rup   = w_g & (w_rs | r2_sig[3]);
  assign w_man_r = {1'b0, r2_sig[SW-2:3]} + MRW'(w_rup);
  assign w_exp3  = r2_exp + EW'(w_man_r[MAN_W]);

  always_comb begin
    w_res = '0;
    w_fl  = '0;
    if (r2_spec) begin
      w_res = r2_spec_res;
      w_fl  = r2_spec_fl;
    end else if (r2_zero) begin
      w_res = '0;
    end else if (w_exp3[EW-1] || w_exp3 == '0) begin
      w_res        = {r2_sign, {(W-1){1'b0}}};
      w_fl.underflow = 1'b1;
      w_fl.inexact   = 1'b1;
    end else if (w_exp3 >= EW'(EMAX)) begin
      w_res         = {r2_sign, EMAX, {MAN_W{1'b0}}};
      w_fl.overflow = 1'b1;
      w_fl.inexact  = 1'b1;
    end else begin
      w_res        = {r2_sign, w_exp3[EXP_W-1:0], w_man_r[MAN_W-1:0]};
      w_fl.inexact = w_g | w_rs;
    end
  end

  logic         r_out_valid;
  logic [W-1:0] r_result;
  fp_flags_t    r_flags;

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_adv) begin
      r1_valid    <= bus.in_valid;
      r1_spec     <= w_spec;
      r1_spec_res <= w_spec_res;
      r1_spec_fl  <= w_spec_fl;
      r1_sign     <= w_s_hi;
      r1_eff_sub  <= (w_sa != w_sb);
      r1_exp      <= w_e_hi;
      r1_sig_a    <= {1'b1, w_m_hi, 3'b000};
      r1_sig_b    <= w_sig_b;

      r2_valid    <= r1_valid;
      r2_spec     <= r1_spec;
      r2_spec_res <= r1_spec_res;
      r2_spec_fl  <= r1_spec_fl;
      r2_sign     <= r1_sign;
      r2_zero     <= (w_sum == '0);
      r2_exp      <= w_exp2;
      r2_sig      <= w_norm;

      r_out_valid <= r2_valid;
      r_result    <= w_res;
      r_flags     <= w_fl;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (bfloat16) with hand-computed results.
module tb_fp_addsub_pipe;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic [3:0]  fl;
  } vec_t;

  logic clock = 1'b0;
  logic nreset;
  always #5 clock = ~clock;

  fp_addsub_pipe_if #(.W(16)) bus ();

  fp_addsub_pipe dut (
    .clock (clock),
    .nreset(nreset),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   last_out_cyc = 0;
  int   stall_cnt = 0;
  logic prev_stall = 1'b0;
  logic [15:0] held_res;
  logic [3:0]  held_fl;
  vec_t exp_q[$];
  vec_t tbl [18];
  logic acc;
  int   acc_c, n0, idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // One cycle: drive at negedge, observe handshakes, then cross the posedge.
  task automatic step(input logic iv, input vec_t v, input logic ordy, output logic accepted);
    vec_t e;
    @(negedge clock);
    cyc++;
    bus.in_valid  = iv;
    bus.a         = v.a;
    bus.b         = v.b;
    bus.sub       = v.sub;
    bus.out_ready = ordy;
    #1;
    accepted = iv & bus.in_ready;
    if (accepted) exp_q.push_back(v);
    if (bus.out_valid === 1'b1 && !ordy) begin
      chk("in_ready_stall", 32'(bus.in_ready), 32'd0);
      if (prev_stall) begin
        chk("held_result", 32'(bus.result), 32'(held_res));
        chk("held_flags", 32'(bus.flags), 32'(held_fl));
      end
      held_res   = bus.result;
      held_fl    = bus.flags;
      prev_stall = 1'b1;
      stall_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
    if (bus.out_valid === 1'b1 && ordy) begin
      chk("handoff_has_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", 32'(bus.result), 32'(e.res));
        chk("flags", 32'(bus.flags), 32'(e.fl));
      end
      n_out++;
      last_out_cyc = cyc;
    end
    @(posedge clock);
  endtask

  initial begin
    tbl = '{
      '{16'h3F80, 16'h4000, 1'b0, 16'h4040, 4'h0},
      '{16'h3F80, 16'h3F80, 1'b1, 16'h0000, 4'h0},
      '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'h0},
      '{16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 4'h1},
      '{16'h3F80, 16'h3BC0, 1'b0, 16'h3F81, 4'h1},
      '{16'h7F80, 16'hFF80, 1'b0, 16'h7FC0, 4'h8},
      '{16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 4'h0},
      '{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 4'h5},
      '{16'h4040, 16'h3F80, 1'b1, 16'h4000, 4'h0},
      '{16'h3F80, 16'h4000, 1'b1, 16'hBF80, 4'h0},
      '{16'h0000, 16'h3F80, 1'b1, 16'hBF80, 4'h0},
      '{16'h3F80, 16'h7F80, 1'b0, 16'h7F80, 4'h0},
      '{16'h3F80, 16'h0001, 1'b0, 16'h3F80, 4'h0},
      '{16'h0080, 16'h00C0, 1'b1, 16'h8000, 4'h3},
      '{16'h3F80, 16'h3380, 1'b0, 16'h3F80, 4'h1},
      '{16'h3F80, 16'h3380, 1'b1, 16'h3F80, 4'h1},
      '{16'h4040, 16'h4040, 1'b0, 16'h40C0, 4'h0},
      '{16'h0000, 16'h8000, 1'b0, 16'h0000, 4'h0}
    };

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    nreset        = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_result", 32'(bus.result), 32'd0);
    chk("reset_flags", 32'(bus.flags), 32'd0);
    nreset = 1'b1;
    @(posedge clock);
    #1;
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Latency of a single op with an always-ready consumer
    n0 = n_out;
    step(1'b1, tbl[0], 1'b1, acc);
    acc_c = cyc;
    chk("first_accept", 32'(acc), 32'd1);
    repeat (3) step(1'b0, tbl[0], 1'b1, acc);
    chk("single_op_count", 32'(n_out - n0), 32'd1);
    chk("latency", 32'(last_out_cyc - acc_c), 32'd3);

    // Back-to-back stream of every directed vector
    n0 = n_out;
    for (int i = 0; i < 18; i++) step(1'b1, tbl[i], 1'b1, acc);
    repeat (5) step(1'b0, tbl[0], 1'b1, acc);
    chk("stream_count", 32'(n_out - n0), 32'd18);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: consumer stalls for five cycles mid-stream
    n0 = n_out;
    idx = 0;
    stall_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step(idx < 10, tbl[(idx < 10) ? idx : 0], !(c >= 5 && c < 10), acc);
      if (acc) idx++;
    end
    chk("bp_count", 32'(n_out - n0), 32'd10);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_stall_cycles", 32'(stall_cnt), 32'd5);

    // Reset with three ops in flight and the output stalled
    for (int i = 3; i < 6; i++) step(1'b1, tbl[i], 1'b1, acc);
    @(negedge clock);
    nreset        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clock);
    #1;
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_result", 32'(bus.result), 32'd0);
    nreset = 1'b1;
    exp_q.delete();
    n0 = n_out;
    step(1'b1, tbl[16], 1'b1, acc);
    acc_c = cyc;
    repeat (5) step(1'b0, tbl[0], 1'b1, acc);
    chk("post_reset_count", 32'(n_out - n0), 32'd1);
    chk("post_reset_latency", 32'(last_out_cyc - acc_c), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
